// File: rtl/inverse_butterfly_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : inverse_butterfly_unit_if
// Brief    : Handshake and data bundle for the radix-2 inverse butterfly.
// Revision : 1.0
// ============================================================================
interface inverse_butterfly_unit_if #(
  parameter int HALF_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*HALF_W-1:0]   Y;
  logic [2*HALF_W-1:0]   Z;
  logic [2*HALF_W-1:0]   w;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*HALF_W-1:0]   A;
  logic [2*HALF_W-1:0]   B;
  logic                  ovf;

  modport master (
    output in_valid, Y, Z, w, out_ready,
    input  in_ready, out_valid, A, B, ovf
  );

  modport slave (
    input  in_valid, Y, Z, w, out_ready,
    output in_ready, out_valid, A, B, ovf
  );
endinterface
`default_nettype wire

// File: rtl/inverse_butterfly_unit.sv
`default_nettype none
// ============================================================================
// Module   : inverse_butterfly_unit
// Brief    : 3-stage radix-2 inverse butterfly, A=(Y+Z)/2, B=((Y-Z)/2)*conj(w).
//            Define INV_BFLY_SAT_EN to saturate B and enable the sticky ovf flag.
// Revision : 1.0
// ============================================================================
module inverse_butterfly_unit #(
  parameter int FRAC_BITS = 10,
  parameter int HALF_W    = 16
) (
  input  wire logic               Clk,
  input  wire logic               Rst,
  inverse_butterfly_unit_if.slave bus
);
  localparam int W = 2 * HALF_W;
  localparam logic signed [W:0] C_RND  = (W+1)'(2 ** (FRAC_BITS - 1));
  localparam logic signed [W:0] C_MAXV = (W+1)'(2 ** (HALF_W - 1) - 1);
  localparam logic signed [W:0] C_MINV = (W+1)'(-(2 ** (HALF_W - 1)));

  logic advance;

  logic                     s1_vld_q;
  logic [W-1:0]             s1_a_q;
  logic signed [HALF_W-1:0] s1_dr_q, s1_di_q;
  logic [W-1:0]             s1_w_q;

  logic                     s2_vld_q;
  logic [W-1:0]             s2_a_q;
  logic signed [W-1:0]      s2_p_rr_q, s2_p_ii_q, s2_p_ir_q, s2_p_ri_q;

  logic                     out_vld_q;
  logic [W-1:0]             a_out_q, b_out_q;

  assign advance      = !out_vld_q || bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_valid = out_vld_q;
  assign bus.A        = a_out_q;
  assign bus.B        = b_out_q;

  // Stage 1: halved sum and difference; the 17-bit intermediate cannot overflow
  logic signed [HALF_W-1:0] y_re, y_im, z_re, z_im;
  logic signed [HALF_W:0]   sum_re, sum_im, dif_re, dif_im;
  logic [W-1:0]             s1_a_d;

  assign y_re   = bus.Y[W-1:HALF_W];
  assign y_im   = bus.Y[HALF_W-1:0];
  assign z_re   = bus.Z[W-1:HALF_W];
  assign z_im   = bus.Z[HALF_W-1:0];
  assign sum_re = (HALF_W+1)'(y_re) + (HALF_W+1)'(z_re);
  assign sum_im = (HALF_W+1)'(y_im) + (HALF_W+1)'(z_im);
  assign dif_re = (HALF_W+1)'(y_re) - (HALF_W+1)'(z_re);
  assign dif_im = (HALF_W+1)'(y_im) - (HALF_W+1)'(z_im);
  assign s1_a_d = {sum_re[HALF_W:1], sum_im[HALF_W:1]};

  // Stage 2: the four partial products of d * conj(w)
  logic signed [HALF_W-1:0] s1_wr, s1_wi;
  logic signed [W-1:0]      p_rr_d, p_ii_d, p_ir_d, p_ri_d;

  assign s1_wr  = s1_w_q[W-1:HALF_W];
  assign s1_wi  = s1_w_q[HALF_W-1:0];
  assign p_rr_d = W'(s1_dr_q) * W'(s1_wr);
  assign p_ii_d = W'(s1_di_q) * W'(s1_wi);
  assign p_ir_d = W'(s1_di_q) * W'(s1_wr);
  assign p_ri_d = W'(s1_dr_q) * W'(s1_wi);

  // Stage 3: combine, round half-up, reduce to component width
  logic signed [W:0]        br_rnd, bi_rnd, br_shf, bi_shf;
  logic [HALF_W-1:0]        br_d, bi_d;

  assign br_rnd = (W+1)'(s2_p_rr_q) + (W+1)'(s2_p_ii_q) + C_RND;
  assign bi_rnd = (W+1)'(s2_p_ir_q) - (W+1)'(s2_p_ri_q) + C_RND;
  assign br_shf = br_rnd >>> FRAC_BITS;
  assign bi_shf = bi_rnd >>> FRAC_BITS;

`ifdef INV_BFLY_SAT_EN
  logic clip_d;
  logic ovf_q;

  always_comb begin
    br_d   = br_shf[HALF_W-1:0];
    bi_d   = bi_shf[HALF_W-1:0];
    clip_d = 1'b0;
    if (br_shf > C_MAXV) begin
      br_d   = {1'b0, {(HALF_W-1){1'b1}}};
      clip_d = 1'b1;
    end else if (br_shf < C_MINV) begin
      br_d   = {1'b1, {(HALF_W-1){1'b0}}};
      clip_d = 1'b1;
    end
    if (bi_shf > C_MAXV) begin
      bi_d   = {1'b0, {(HALF_W-1){1'b1}}};
      clip_d = 1'b1;
    end else if (bi_shf < C_MINV) begin
      bi_d   = {1'b1, {(HALF_W-1){1'b0}}};
      clip_d = 1'b1;
    end
  end

  // Bubbles carry stale data, so only a valid load may raise the flag
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ovf_q <= 1'b0;
    end else if (advance && s2_vld_q && clip_d) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_bits;

  assign br_d        = br_shf[HALF_W-1:0];
  assign bi_d        = bi_shf[HALF_W-1:0];
  assign unused_bits = ^{br_shf[W:HALF_W], bi_shf[W:HALF_W], C_MAXV, C_MINV};
  assign bus.ovf     = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      a_out_q   <= '0;
      b_out_q   <= '0;
    end else if (advance) begin
      s1_vld_q  <= bus.in_valid;
      s2_vld_q  <= s1_vld_q;
      out_vld_q <= s2_vld_q;
      a_out_q   <= s2_a_q;
      b_out_q   <= {br_d, bi_d};
    end
  end

  always_ff @(posedge Clk) begin
    if (advance) begin
      s1_a_q    <= s1_a_d;
      s1_dr_q   <= dif_re[HALF_W:1];
      s1_di_q   <= dif_im[HALF_W:1];
      s1_w_q    <= bus.w;
      s2_a_q    <= s1_a_q;
      s2_p_rr_q <= p_rr_d;
      s2_p_ii_q <= p_ii_d;
      s2_p_ir_q <= p_ir_d;
      s2_p_ri_q <= p_ri_d;
    end
  end
endmodule
`default_nettype wire

// File: doc/inverse_butterfly_unit.md
Name: inverse_butterfly_unit

Overview:
- Radix-2 inverse butterfly: recovers the butterfly inputs A, B from outputs Y = A + w·B, Z = A − w·B.
- Computes A = (Y+Z)/2 and B = ((Y−Z)/2)·conj(w). This is exact for unit-magnitude twiddles.
- Sits on the IFFT/verification path as the counterpart of MultiplyAddUnit.
- Same packed complex format: {re[31:16], im[15:0]}, each a signed Q5.10 value (1.0 = 0x0400).

Parameters:
- FRAC_BITS, 10, fractional bits per component.
- HALF_W, 16, component width; the packed word is 2·HALF_W.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  synchronous reset, active-high.
- in_valid  input  1  Y/Z/w are valid this cycle.
- in_ready  output  1  the block accepts an input this cycle.
- Y  input  32  packed complex Y.
- Z  input  32  packed complex Z.
- w  input  32  packed complex twiddle.
- out_valid  output  1  A/B are valid.
- out_ready  input  1  the consumer accepts A/B.
- A  output  32  packed complex recovered A.
- B  output  32  packed complex recovered B.
- ovf  output  1  sticky saturation flag.

Behaviour:
- Interface: one clock (Clk); synchronous active-high reset (Rst).
- Reset: all stage valid bits = 0, out_valid = 0, A = 0, B = 0, ovf = 0. Rst has priority over every other event; in-flight data is discarded. in_ready = 1 on the first cycle after reset.
- Pipeline: three register stages (S1, S2, S3 = output registers).
  - Global advance = !out_valid || out_ready.
  - in_ready = advance.
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - When advance = 1, every stage shifts: S1 <= input (valid = in_valid), S2 <= S1, S3 <= S2. When advance = 0, all stages hold.
  - Bubbles propagate and are not collapsed.
  - Latency: 3 cycles from input transfer to out_valid, with out_ready held 1. Throughput: 1 per cycle.
- S1 (sum/difference):
  - s = Y + Z and d = Y − Z, per component, 17-bit signed.
  - Arithmetic shift right by 1 (floor); the result fits in 16 bits with no overflow.
  - Register a = s>>>1, d = d>>>1, and w.
- S2 (multiply): four signed 16×16 → 32-bit products, registered: dr·wr, di·wi, di·wr, dr·wi. a is delayed alongside.
- S3 (combine): Br = dr·wr + di·wi, Bi = di·wr − dr·wi, each 33-bit.
  - Round half-up: add 2^(FRAC_BITS−1), then arithmetic shift right by FRAC_BITS.
  - Reduce to 16 bits per the optional feature.
  - A = a passes through unchanged.
- Holding: while out_valid && !out_ready, A, B and out_valid are stable and no input is accepted.
- Simultaneous Rst and in_valid: reset wins; the input is not accepted.

Optional Feature:
- Macro: INV_BFLY_SAT_EN.
- Defined:
  - A Br/Bi result outside [−32768, 32767] clamps to 0x8000 / 0x7FFF.
  - ovf is set to 1 on the S3 load of any clamped result and stays set until Rst.
- Undefined:
  - Br/Bi wrap (take the low 16 bits).
  - ovf is tied to 0.
- All other behaviour is identical.

Test Plan:
- Identity twiddle: w=0x04000000, Y=0x0C000800, Z=0x04000000, out_ready=1.
  → 3 cycles later out_valid=1, A=0x08000400, B=0x04000400.
- j twiddle: w=0x00000400, Y=0x04000400, Z=0xFC00FC00.
  → A=0x00000000, B=0x0400FC00.
- Rounding: w=0x00010000, Y=0x06000000, Z=0.
  → A=0x03000000, B=0x00010000 (truncation would give 0).
- Overflow: w=0x08000000, Y=0x7FFF0000, Z=0x80010000.
  → A=0x00000000.
  → With INV_BFLY_SAT_EN: B=0x7FFF0000, ovf=1 and stays 1.
  → Without: B=0xFFFE0000, ovf=0.
- Backpressure: stream 4 distinct inputs back-to-back, out_ready=0 from cycle 3 for 5 cycles.
  → in_ready=0 while out_valid=1 and out_ready=0; A/B stay stable.
  → After release, all 4 results emerge in order with none lost or duplicated.
- Reset mid-stream: pipeline full, Rst=1 for 1 cycle.
  → Next cycle out_valid=0, A=B=0, ovf=0, in_ready=1.
  → No pre-reset result ever appears.
